// File: rtl/eth_tx_arbiter_if.sv
// Requester byte streams plus the RMII TX dibit stream of eth_tx_arbiter.
// The master side drives requests; the slave side is the arbiter.
interface eth_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*8-1:0]       req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       axiov;
    logic [1:0]                 axiod;
    logic [$clog2(NUM_REQ)-1:0] grant;
    logic                       frame_done;
    logic                       underrun;

    modport master (
        output req_valid, req_data, req_last,
        input  req_ready, axiov, axiod, grant, frame_done, underrun
    );

    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready, axiov, axiod, grant, frame_done, underrun
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin RMII TX scheduler: preamble/SFD, LSB-first payload dibits, then inter-frame gap.
// Defining ETH_TX_FCS_EN appends a CRC-32 FCS after the payload.
module eth_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned IFG_DIBITS = 48
) (
    input logic             clk,
    input logic             rst_n,
    eth_tx_arbiter_if.slave bus
);
    localparam int unsigned GrantW = $clog2(NUM_REQ);
    localparam int unsigned CntMax = (IFG_DIBITS > 32) ? IFG_DIBITS : 32;
    localparam int unsigned CntW   = $clog2(CntMax);

`ifdef ETH_TX_FCS_EN
    typedef enum logic [2:0] {StIdle, StPreamble, StPayload, StFcs, StIfg} state_e;
`else
    typedef enum logic [1:0] {StIdle, StPreamble, StPayload, StIfg} state_e;
`endif

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [1:0]          dib_q, dib_d;
    logic [7:0]          byte_q, byte_d;
    logic                last_q, last_d;
    logic [GrantW-1:0]   grant_q, grant_d;
    logic [GrantW-1:0]   rr_q, rr_d;
    logic                axiov_q, axiov_d;
    logic [1:0]          axiod_q, axiod_d;
    logic                frame_done_q, frame_done_d;
    logic                underrun_q, underrun_d;

    logic [GrantW-1:0]   pick, pick_lo, pick_hi;
    logic                found_lo, found_hi;
    logic                fetch;
    logic                cur_valid, cur_last;
    logic [7:0]          cur_data;

`ifdef ETH_TX_FCS_EN
    logic [31:0]         crc_q, crc_d;
    logic [31:0]         fcs;

    // Reflected CRC-32, one byte per call.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign fcs = ~crc_q;
`endif

    // Requesters at or after rr_q win first; otherwise wrap to the lowest valid index.
    always_comb begin
        pick_lo  = '0;
        pick_hi  = '0;
        found_lo = 1'b0;
        found_hi = 1'b0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                pick_lo  = GrantW'(i);
                found_lo = 1'b1;
                if (GrantW'(i) >= rr_q) begin
                    pick_hi  = GrantW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (GrantW'(i) == grant_q) begin
                cur_valid = bus.req_valid[i];
                cur_last  = bus.req_last[i];
                cur_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    // A byte is fetched during the SFD dibit and the last dibit of every non-final byte.
    always_comb begin
        fetch = ((state_q == StPreamble) && (cnt_q == CntW'(31))) ||
                ((state_q == StPayload) && (dib_q == 2'd3) && !last_q);
        bus.req_ready = '0;
        if (fetch) begin
            bus.req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dib_d        = dib_q;
        byte_d       = byte_q;
        last_d       = last_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        axiov_d      = axiov_q;
        axiod_d      = axiod_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
`ifdef ETH_TX_FCS_EN
        crc_d        = crc_q;
`endif
        if (fetch) begin
            if (cur_valid) begin
                byte_d  = cur_data;
                last_d  = cur_last;
                dib_d   = 2'd0;
                axiod_d = cur_data[1:0];
                state_d = StPayload;
`ifdef ETH_TX_FCS_EN
                crc_d   = crc_byte(crc_q, cur_data);
`endif
            end else begin
                axiov_d    = 1'b0;
                axiod_d    = 2'b00;
                underrun_d = 1'b1;
                cnt_d      = '0;
                state_d    = StIfg;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found_lo) begin
                        grant_d = pick;
                        rr_d    = (pick == GrantW'(NUM_REQ - 1)) ? '0 : pick + GrantW'(1);
                        cnt_d   = '0;
                        last_d  = 1'b0;
                        axiov_d = 1'b1;
                        axiod_d = 2'b01;
                        state_d = StPreamble;
`ifdef ETH_TX_FCS_EN
                        crc_d   = '1;
`endif
                    end
                end
                StPreamble: begin
                    cnt_d   = cnt_q + CntW'(1);
                    axiod_d = (cnt_q == CntW'(30)) ? 2'b11 : 2'b01;
                end
                StPayload: begin
                    if (dib_q != 2'd3) begin
                        dib_d   = dib_q + 2'd1;
                        axiod_d = byte_q[{dib_d, 1'b0} +: 2];
                    end else begin
                        cnt_d = '0;
`ifdef ETH_TX_FCS_EN
                        axiod_d = fcs[1:0];
                        state_d = StFcs;
`else
                        axiov_d      = 1'b0;
                        axiod_d      = 2'b00;
                        frame_done_d = 1'b1;
                        state_d      = StIfg;
`endif
                    end
                end
`ifdef ETH_TX_FCS_EN
                StFcs: begin
                    if (cnt_q == CntW'(15)) begin
                        cnt_d        = '0;
                        axiov_d      = 1'b0;
                        axiod_d      = 2'b00;
                        frame_done_d = 1'b1;
                        state_d      = StIfg;
                    end else begin
                        cnt_d   = cnt_q + CntW'(1);
                        axiod_d = fcs[{cnt_d[3:0], 1'b0} +: 2];
                    end
                end
`endif
                StIfg: begin
                    if (cnt_q == CntW'(IFG_DIBITS - 1)) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            dib_q        <= '0;
            byte_q       <= '0;
            last_q       <= 1'b0;
            grant_q      <= '0;
            rr_q         <= '0;
            axiov_q      <= 1'b0;
            axiod_q      <= 2'b00;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef ETH_TX_FCS_EN
            crc_q        <= '1;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dib_q        <= dib_d;
            byte_q       <= byte_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            axiov_q      <= axiov_d;
            axiod_q      <= axiod_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
`ifdef ETH_TX_FCS_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign bus.axiov      = axiov_q;
    assign bus.axiod      = axiod_q;
    assign bus.grant      = grant_q;
    assign bus.frame_done = frame_done_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: outputs are logged every falling edge and the
// scenario tasks compare the log against hand-derived cycle positions and dibits.
module tb_eth_tx_arbiter;
    localparam int NReq = 2;
    localparam int GW   = $clog2(NReq);
    localparam int LogN = 8192;
`ifdef ETH_TX_FCS_EN
    localparam int Fcs = 16;
`else
    localparam int Fcs = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    eth_tx_arbiter_if #(.NUM_REQ(NReq)) bus ();

    eth_tx_arbiter #(
        .NUM_REQ   (NReq),
        .IFG_DIBITS(48)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic          cap_v   [LogN];
    logic [1:0]    cap_d   [LogN];
    logic [NReq-1:0] cap_rdy [LogN];
    logic [GW-1:0] cap_g   [LogN];
    logic          cap_fd  [LogN];
    logic          cap_ur  [LogN];
    logic [NReq-1:0] fire = '0;

    logic [7:0] fr_data [NReq][16];
    int         fr_len  [NReq];
    int         fr_idx  [NReq];
    int         fr_drop [NReq];
    logic       fr_en   [NReq];

    // Output log, one entry per cycle, taken on the falling edge.
    initial forever begin
        @(negedge clk);
        if (cyc < LogN) begin
            cap_v[cyc]   = bus.axiov;
            cap_d[cyc]   = bus.axiod;
            cap_rdy[cyc] = bus.req_ready;
            cap_g[cyc]   = bus.grant;
            cap_fd[cyc]  = bus.frame_done;
            cap_ur[cyc]  = bus.underrun;
        end
        fire = bus.req_ready & bus.req_valid;
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic drive();
        for (int i = 0; i < NReq; i++) begin
            bus.req_valid[i]        = fr_en[i] && (fr_idx[i] < fr_len[i]) && (fr_idx[i] != fr_drop[i]);
            bus.req_data[8*i +: 8]  = fr_data[i][fr_idx[i] % 16];
            bus.req_last[i]         = (fr_idx[i] == fr_len[i] - 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NReq; i++) begin
            if (fire[i]) fr_idx[i]++;
        end
        drive();
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic arm(input int r, input int len, input int drop);
        fr_len[r]  = len;
        fr_idx[r]  = 0;
        fr_drop[r] = drop;
        fr_en[r]   = 1'b1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NReq; i++) fr_en[i] = 1'b0;
        drive();
        #2 rst_n = 1'b0;
        step();
        step();
        #4 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NReq; i++) begin
            fr_en[i] = 1'b0; fr_len[i] = 0; fr_idx[i] = 0; fr_drop[i] = -1;
        end
        drive();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.axiov, bus.axiod, bus.frame_done, bus.underrun, bus.req_ready, bus.grant} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%b fd=%b ur=%b rdy=%b g=%0d want all 0",
                     bus.axiov, bus.axiod, bus.frame_done, bus.underrun, bus.req_ready, bus.grant);
        end
        step();
        step();
        #4 rst_n = 1'b1;
        step();
        step();
        checks++;
        if (bus.axiov !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got axiov=%b want 0", bus.axiov);
        end
    endtask

    task automatic test_single_frame();
        int s, e, n, u;
        logic [1:0] exp_pay [8];
        exp_pay = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00};
        fr_data[0][0] = 8'hA5;
        fr_data[0][1] = 8'h3C;
        arm(0, 2, -1);
        s = cyc;
        drive();
        wait_to(s + 100 + Fcs);
        fr_en[0] = 1'b0;
        drive();
        checks++;
        if ({cap_v[s], cap_v[s+1], cap_g[s+1]} !== {1'b0, 1'b1, GW'(0)}) begin
            errors++;
            $display("FAIL t1_latency got v=%b%b g=%0d want v=01 g=0", cap_v[s], cap_v[s+1], cap_g[s+1]);
        end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if ({cap_v[s+1+k], cap_d[s+1+k]} !== {1'b1, ((k == 31) ? 2'b11 : 2'b01)}) begin
                errors++;
                $display("FAIL t1_preamble[%0d] got v=%b d=%b", k, cap_v[s+1+k], cap_d[s+1+k]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({cap_v[s+33+k], cap_d[s+33+k]} !== {1'b1, exp_pay[k]}) begin
                errors++;
                $display("FAIL t1_payload[%0d] got v=%b d=%b want v=1 d=%b",
                         k, cap_v[s+33+k], cap_d[s+33+k], exp_pay[k]);
            end
        end
        e = s + 41 + Fcs;
        checks++;
        if ({cap_v[e-1], cap_v[e], cap_fd[e-1], cap_fd[e], cap_fd[e+1]} !== 5'b10010) begin
            errors++;
            $display("FAIL t1_frame_end got v=%b%b fd=%b%b%b want v=10 fd=010",
                     cap_v[e-1], cap_v[e], cap_fd[e-1], cap_fd[e], cap_fd[e+1]);
        end
        n = 0;
        for (int k = s; k <= e + 10; k++) if (cap_rdy[k][0]) n++;
        checks++;
        if (n != 2 || cap_rdy[s+32] !== 2'b01 || cap_rdy[s+36] !== 2'b01) begin
            errors++;
            $display("FAIL t1_ready got count=%0d rdy@32=%b rdy@36=%b want 2 01 01",
                     n, cap_rdy[s+32], cap_rdy[s+36]);
        end
        n = 0;
        u = 0;
        for (int k = e; k <= e + 48; k++) if (cap_v[k]) n++;
        for (int k = s; k <= e + 48; k++) if (cap_ur[k]) u++;
        checks++;
        if (n != 0 || u != 0) begin
            errors++;
            $display("FAIL t1_gap got valid=%0d underrun=%0d want 0 0", n, u);
        end
    endtask

    task automatic test_simultaneous();
        int s, l, f, n;
        logic [1:0] exp0 [4];
        logic [1:0] exp1 [4];
        exp0 = '{2'b10, 2'b00, 2'b01, 2'b00};
        exp1 = '{2'b00, 2'b01, 2'b11, 2'b00};
        do_reset();
        fr_data[0][0] = 8'h12;
        fr_data[1][0] = 8'h34;
        arm(0, 1, -1);
        arm(1, 1, -1);
        s = cyc;
        drive();
        l = s + 36 + Fcs;
        f = l + 50;
        wait_to(f + 36 + Fcs + 55);
        checks++;
        if ({cap_v[s+1], cap_g[s+1]} !== {1'b1, GW'(0)}) begin
            errors++;
            $display("FAIL t2_first_grant got v=%b g=%0d want v=1 g=0", cap_v[s+1], cap_g[s+1]);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_d[s+33+k] !== exp0[k] || cap_d[f+32+k] !== exp1[k]) begin
                errors++;
                $display("FAIL t2_payload[%0d] got %b/%b want %b/%b",
                         k, cap_d[s+33+k], cap_d[f+32+k], exp0[k], exp1[k]);
            end
        end
        n = 0;
        for (int k = l + 1; k <= l + 49; k++) if (cap_v[k]) n++;
        checks++;
        if (cap_v[l] !== 1'b1 || n != 0 || cap_v[f] !== 1'b1 || cap_g[f] !== GW'(1)) begin
            errors++;
            $display("FAIL t2_gap got last=%b gapvalid=%0d start=%b g=%0d want 1 0 1 1",
                     cap_v[l], n, cap_v[f], cap_g[f]);
        end
        n = 0;
        for (int k = s + 1; k <= l; k++) if (cap_rdy[k][1]) n++;
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL t2_nongranted_ready got %0d cycles want 0", n);
        end
        checks++;
        if (cap_fd[f+36+Fcs] !== 1'b1) begin
            errors++;
            $display("FAIL t2_done got fd=%b want 1", cap_fd[f+36+Fcs]);
        end
    endtask

    task automatic test_fairness();
        int s, l, f1, m, f2, nn, f3;
        fr_data[1][0] = 8'h5A;
        arm(1, 1, -1);
        s = cyc;
        drive();
        l = s + 36 + Fcs;
        wait_to(l + 4);
        fr_data[0][0] = 8'h01;
        fr_data[1][0] = 8'h02;
        arm(0, 1, -1);
        arm(1, 1, -1);
        drive();
        f1 = l + 50;
        m  = f1 + 35 + Fcs;
        wait_to(m + 4);
        fr_data[0][0] = 8'h03;
        arm(0, 1, -1);
        drive();
        f2 = m + 50;
        nn = f2 + 35 + Fcs;
        f3 = nn + 50;
        wait_to(f3 + 36 + Fcs + 55);
        checks++;
        if ({cap_v[s+1], cap_g[s+1]} !== {1'b1, GW'(1)}) begin
            errors++;
            $display("FAIL t3_alone got v=%b g=%0d want v=1 g=1", cap_v[s+1], cap_g[s+1]);
        end
        checks++;
        if ({cap_v[f1], cap_g[f1], cap_d[f1+32]} !== {1'b1, GW'(0), 2'b01}) begin
            errors++;
            $display("FAIL t3_second got v=%b g=%0d d=%b want v=1 g=0 d=01",
                     cap_v[f1], cap_g[f1], cap_d[f1+32]);
        end
        checks++;
        if ({cap_v[f2], cap_g[f2], cap_d[f2+32]} !== {1'b1, GW'(1), 2'b10}) begin
            errors++;
            $display("FAIL t3_rotate got v=%b g=%0d d=%b want v=1 g=1 d=10",
                     cap_v[f2], cap_g[f2], cap_d[f2+32]);
        end
        checks++;
        if ({cap_v[f3], cap_g[f3], cap_d[f3+32]} !== {1'b1, GW'(0), 2'b11}) begin
            errors++;
            $display("FAIL t3_third got v=%b g=%0d d=%b want v=1 g=0 d=11",
                     cap_v[f3], cap_g[f3], cap_d[f3+32]);
        end
    endtask

    task automatic test_underrun();
        int s, n, fd;
        fr_data[0][0] = 8'hFF;
        fr_data[0][1] = 8'h00;
        arm(0, 2, 1);
        s = cyc;
        drive();
        wait_to(s + 40);
        fr_drop[0] = -1;
        drive();
        wait_to(s + 122 + Fcs + 55);
        checks++;
        if ({cap_v[s+36], cap_d[s+36], cap_rdy[s+36]} !== {1'b1, 2'b11, 2'b01}) begin
            errors++;
            $display("FAIL t4_fetch got v=%b d=%b rdy=%b want 1 11 01",
                     cap_v[s+36], cap_d[s+36], cap_rdy[s+36]);
        end
        checks++;
        if ({cap_v[s+37], cap_ur[s+36], cap_ur[s+37], cap_ur[s+38]} !== 4'b0010) begin
            errors++;
            $display("FAIL t4_underrun got v=%b ur=%b%b%b want v=0 ur=010",
                     cap_v[s+37], cap_ur[s+36], cap_ur[s+37], cap_ur[s+38]);
        end
        n  = 0;
        fd = 0;
        for (int k = s + 37; k <= s + 85; k++) if (cap_v[k]) n++;
        for (int k = s; k <= s + 85; k++) if (cap_fd[k]) fd++;
        checks++;
        if (n != 0 || fd != 0) begin
            errors++;
            $display("FAIL t4_gap got valid=%0d frame_done=%0d want 0 0", n, fd);
        end
        checks++;
        if ({cap_v[s+86], cap_v[s+118], cap_d[s+118], cap_fd[s+122+Fcs]} !== {1'b1, 1'b1, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL t4_restart got v=%b v=%b d=%b fd=%b want 1 1 00 1",
                     cap_v[s+86], cap_v[s+118], cap_d[s+118], cap_fd[s+122+Fcs]);
        end
    endtask

    task automatic test_async_reset();
        int s, s2, u;
        fr_data[0][0] = 8'h11;
        fr_data[0][1] = 8'h22;
        fr_data[0][2] = 8'h33;
        arm(0, 3, -1);
        s = cyc;
        drive();
        wait_to(s + 36);
        checks++;
        if ({bus.axiov, bus.req_ready} !== {1'b1, 2'b01}) begin
            errors++;
            $display("FAIL t5_pre got v=%b rdy=%b want 1 01", bus.axiov, bus.req_ready);
        end
        #4 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.axiov, bus.axiod, bus.req_ready, bus.frame_done, bus.underrun, bus.grant} !== '0) begin
            errors++;
            $display("FAIL t5_async got v=%b d=%b rdy=%b fd=%b ur=%b g=%0d want all 0",
                     bus.axiov, bus.axiod, bus.req_ready, bus.frame_done, bus.underrun, bus.grant);
        end
        fr_en[0] = 1'b0;
        drive();
        step();
        step();
        #4 rst_n = 1'b1;
        step();
        fr_data[1][0] = 8'h77;
        arm(1, 1, -1);
        s2 = cyc;
        drive();
        wait_to(s2 + 3);
        u = 0;
        for (int k = s; k <= s2 + 2; k++) if (cap_ur[k]) u++;
        checks++;
        if (u != 0) begin
            errors++;
            $display("FAIL t5_no_underrun got %0d pulses want 0", u);
        end
        checks++;
        if ({cap_v[s2], cap_v[s2+1], cap_g[s2+1]} !== {1'b0, 1'b1, GW'(1)}) begin
            errors++;
            $display("FAIL t5_regrant got v=%b%b g=%0d want v=01 g=1", cap_v[s2], cap_v[s2+1], cap_g[s2+1]);
        end
        wait_to(s2 + 36 + Fcs + 55);
    endtask

    task automatic test_long_frame();
        int s, e, n;
        logic [7:0]  b;
        logic [31:0] fcs_exp;
        fcs_exp = 32'hCBF4_3926;
        do_reset();
        for (int k = 0; k < 9; k++) fr_data[0][k] = 8'h31 + 8'(k);
        arm(0, 9, -1);
        s = cyc;
        drive();
        e = s + 69 + Fcs;
        wait_to(e + 60);
        for (int k = 0; k < 36; k++) begin
            b = fr_data[0][k/4];
            checks++;
            if ({cap_v[s+33+k], cap_d[s+33+k]} !== {1'b1, b[2*(k%4) +: 2]}) begin
                errors++;
                $display("FAIL t6_payload[%0d] got v=%b d=%b want v=1 d=%b",
                         k, cap_v[s+33+k], cap_d[s+33+k], b[2*(k%4) +: 2]);
            end
        end
`ifdef ETH_TX_FCS_EN
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({cap_v[s+69+k], cap_d[s+69+k]} !== {1'b1, fcs_exp[2*k +: 2]}) begin
                errors++;
                $display("FAIL t6_fcs[%0d] got v=%b d=%b want v=1 d=%b",
                         k, cap_v[s+69+k], cap_d[s+69+k], fcs_exp[2*k +: 2]);
            end
        end
`endif
        n = 0;
        for (int k = s; k <= e + 40; k++) if (cap_v[k]) n++;
        checks++;
        if (n != 32 + 36 + Fcs || cap_v[e] !== 1'b0 || cap_fd[e] !== 1'b1 || cap_fd[e-1] !== 1'b0) begin
            errors++;
            $display("FAIL t6_length got valid=%0d v=%b fd=%b%b want %0d 0 01",
                     n, cap_v[e], cap_fd[e-1], cap_fd[e], 32 + 36 + Fcs);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_simultaneous();
        test_fairness();
        test_underrun();
        test_async_reset();
        test_long_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Round-robin scheduler that shares one RMII transmit dibit stream among NUM_REQ byte-stream requesters.
- Per granted frame: emits preamble and SFD, then serializes payload bytes into dibits (LSB dibit first, RMII order), then enforces the inter-frame gap.
- Output drives the RMII TX pin stage as an axiov/axiod dibit stream.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
IFG_DIBITS, 48, idle dibit cycles after every frame (12 bytes)

Ports:
clk  input  1  system clock (50 MHz RMII clock)
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*8  byte for requester i in bits [8i+7:8i]
req_last  input  NUM_REQ  marks the final payload byte of the frame
req_ready  output  NUM_REQ  byte accepted on an edge where ready&valid; combinational
axiov  output  1  dibit valid
axiod  output  2  dibit data
grant  output  $clog2(NUM_REQ)  current/last granted requester
frame_done  output  1  one-cycle pulse after a frame completes normally
underrun  output  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; axiov=0; axiod=00; grant=0; frame_done=0; underrun=0; req_ready=0; round-robin pointer makes requester 0 highest priority. Takes effect without a clock edge. Reset mid-frame drops the frame silently, with no underrun pulse.
- Registered outputs: axiov, axiod, frame_done, underrun.
- States:
  - IDLE: no output activity.
  - PREAMBLE: 32 dibits.
  - PAYLOAD: 4 dibits per byte.
  - FCS: only with the optional feature.
  - IFG: IFG_DIBITS cycles, axiov=0.
- IDLE:
  - Edge with any req_valid: pick the first valid requester after the last granted one (round robin); grant<=it.
  - Same edge: state<=PREAMBLE, axiov<=1, axiod<=01 (one-cycle latency).
  - If no valid: hold.
- PREAMBLE:
  - Dibits 0..30 = 01 (7x 0x55 plus the low 3 dibits of 0xD5); dibit 31 = 11 (SFD).
  - During dibit 31: req_ready[grant]=1.
- Byte fetch (ready=1 during the last dibit of the preamble or of each payload byte):
  - At the edge: if req_valid[grant], latch data/last, axiod<=data[1:0], continue.
  - If not valid: underrun.
  - Ready is suppressed once a byte with last=1 has been latched.
  - Dibits within a byte: [1:0],[3:2],[5:4],[7:6].
- End of the last byte's 4th dibit:
  - Go to FCS (if enabled) or IFG.
  - axiov<=0; frame_done<=1 for one cycle.
- Underrun (valid low at a fetch edge, current byte not last):
  - axiov<=0, underrun<=1 for one cycle, state<=IFG; grant advances normally.
- IFG:
  - Counts IFG_DIBITS cycles, then IDLE.
  - Requests are ignored during IFG; requester valid may stay high.
- Non-granted requesters: req_ready=0 always.
- Simultaneous requests at the IDLE edge: the round-robin pointer decides.
- req_valid deasserted by a requester between frames: no effect.
- axiov is contiguous for a full frame: 32 + 4*N dibits (+16 with FCS).

Optional Feature:
- Macro: ETH_TX_FCS_EN.
- When defined:
  - CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) is computed over payload bytes only, updated per byte at fetch or per dibit.
  - After the last payload byte, FCS state emits 4 bytes, LSB byte first, LSB dibit first: 16 dibits with axiov=1.
  - frame_done pulses after the final FCS dibit.
  - No ready during FCS.
  - Underrun aborts before FCS.
- When undefined: no FCS state or CRC logic; the frame ends after the last payload byte.

Test Plan:
1. Req0 sends 0xA5, 0x3C (last on 2nd) -> axiov=1 one cycle after valid; 31x01, 11, then 01,01,10,10, 00,11,11,00; axiov low; frame_done 1 cycle; req_ready[0] high exactly 2 cycles; 48 idle cycles.
2. Req0 and req1 valid at the same cycle after reset -> grant=0 frame first; grant=1 preamble starts exactly 49 cycles after req0's last dibit (48 IFG + 1 IDLE).
3. Req1 sends a frame alone, then both request -> req0 wins next, then req1 (round-robin fairness).
4. Req0 drops valid at the 2nd fetch with last=0 -> axiov=0 the next cycle, underrun pulse 1 cycle, no frame_done, 48 idle cycles, back to IDLE.
5. rst_n low mid-payload, no clock edge -> axiov=0, axiod=00, req_ready=0 immediately; after release, a req1 request gets grant=0?no: req0 has priority if both request; req1 alone is granted immediately.
6. With ETH_TX_FCS_EN, payload ASCII "123456789" -> FCS bytes 0x26,0x39,0xF4,0xCB follow the payload; total 32+36+16 valid dibits; frame_done after the final dibit.
